// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU select and controller state types.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_sel_t;
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_FUNCT} aluop_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } mc_state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps (aluop, funct) to the ALU select and flags unsupported funct codes.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      aluop_i,
  input  logic [5:0]  funct_i,
  output alu_sel_t    alu_control_o,
  output logic        funct_valid_o
);
  alu_sel_t fsel;
  always_comb begin
    fsel = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  fsel = ALU_ADD;
      FN_SUB:  fsel = ALU_SUB;
      FN_AND:  fsel = ALU_AND;
      FN_OR:   fsel = ALU_OR;
      FN_SLT:  fsel = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
    alu_control_o = aluop_i == AOP_SUB ? ALU_SUB : aluop_i == AOP_FUNCT ? fsel : ALU_ADD;
  end
endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS Moore control FSM with combinational output decode.
// Define MC_BNE_EN to add bne through the BRANCH state with a registered inversion qualifier.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic       illegal_op
);
  mc_state_t state_q, state_d;
  aluop_t    aluop;
  alu_sel_t  alu_sel;
  logic      pc_write, branch, funct_valid, br_cond;
  alu_decoder u_dec (
    .aluop_i       (aluop),
    .funct_i       (funct),
    .alu_control_o (alu_sel),
    .funct_valid_o (funct_valid)
  );
  assign alu_control = alu_sel;
`ifdef MC_BNE_EN
  logic bne_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bne_q <= 1'b0;
    else if (state_q == S_DECODE) bne_q <= op == OP_BNE;
  assign br_cond = zero ^ bne_q;
`else
  assign br_cond = zero;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = S_FETCH;
    {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a} = '0;
    {alu_src_b, pc_src, pc_write, branch, illegal_op} = '0;
    aluop = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        ir_write = 1'b1;
        pc_write = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            state_d = S_EXECUTE;
            illegal_op = !funct_valid;
          end
          OP_BEQ: state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE: state_d = S_BRANCH;
`endif
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        state_d = state_q == S_ADDIEX ? S_ADDIWB : op == OP_LW ? S_MEMRD : S_MEMWR;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        iord = 1'b1;
      end
      S_MEMWB: {reg_write, mem_to_reg} = 2'b11;
      S_MEMWR: {iord, mem_write} = 2'b11;
      S_EXECUTE: begin
        state_d = S_ALUWB;
        alu_src_a = 1'b1;
        aluop = AOP_FUNCT;
      end
      S_ALUWB:  {reg_write, reg_dst} = 2'b11;
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop = AOP_SUB;
        branch = 1'b1;
        pc_src = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase
    pc_en = pc_write | (branch & br_cond);
    // Reset holds state at FETCH, so FETCH's enables must be masked until release.
    if (!rst_n) begin
      {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a} = '0;
      {alu_src_b, pc_src, pc_en, illegal_op} = '0;
      aluop = AOP_ADD;
    end
  end
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed per-state output checks for the multicycle controller.
module tb_mips_mc_controller;
  logic clk = 0, rst_n = 0, zero = 0;
  logic [5:0] op = 6'b0, funct = 6'b100000;
  logic iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [15:0] outs;
  int checks = 0, errors = 0;

  mips_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .alu_control(alu_control), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Order: iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, pc_en, alu_control, illegal_op
  assign outs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, pc_src, pc_en, alu_control, illegal_op};

  localparam logic [15:0] E_RST    = {7'b0000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_FETCH  = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
  localparam logic [15:0] E_DEC    = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_DECILL = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b1};
  localparam logic [15:0] E_ADR    = {7'b0000001, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMRD  = {7'b1000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWB  = {7'b0000110, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWR  = {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_ALUWB  = {7'b0001010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_ADDIWB = {7'b0000010, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] E_BR_T   = {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0};
  localparam logic [15:0] E_BR_N   = {7'b0000001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0};
  localparam logic [15:0] E_JUMP   = {7'b0000000, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (outs !== E_RST) begin errors++; $display("FAIL rst_hold: got %b expected %b", outs, E_RST); end
    cyc;
    rst_n = 1;
    #1;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL rst_fetch: got %b expected %b", outs, E_FETCH); end
    op = 6'b100011;
    cyc; cyc; cyc;
    checks++; if (outs !== E_MEMRD) begin errors++; $display("FAIL rst_pre_memrd: got %b expected %b", outs, E_MEMRD); end
    #2 rst_n = 0;
    #1;
    checks++; if (outs !== E_RST) begin errors++; $display("FAIL rst_mid_memrd: got %b expected %b", outs, E_RST); end
    cyc;
    checks++; if (outs !== E_RST) begin errors++; $display("FAIL rst_after_edge: got %b expected %b", outs, E_RST); end
    rst_n = 1;
    #1;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL rst_release_fetch: got %b expected %b", outs, E_FETCH); end
    cyc;
    checks++; if (outs !== E_DEC) begin errors++; $display("FAIL rst_then_decode: got %b expected %b", outs, E_DEC); end
    op = 6'b111111;
    #1;
    checks++; if (outs !== E_DECILL) begin errors++; $display("FAIL rst_decode_ill: got %b expected %b", outs, E_DECILL); end
    cyc;
  endtask

  task automatic test_add;
    op = 6'b000000; funct = 6'b100000;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL add_fetch: got %b expected %b", outs, E_FETCH); end
    cyc;
    checks++; if (outs !== E_DEC) begin errors++; $display("FAIL add_decode: got %b expected %b", outs, E_DEC); end
    cyc;
    checks++; if (outs !== {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0}) begin errors++; $display("FAIL add_exec: got %b", outs); end
    cyc;
    checks++; if (outs !== E_ALUWB) begin errors++; $display("FAIL add_aluwb: got %b expected %b", outs, E_ALUWB); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL add_next_fetch: got %b expected %b", outs, E_FETCH); end
  endtask

  task automatic test_lw_sw;
    op = 6'b100011;
    cyc;
    checks++; if (outs !== E_DEC) begin errors++; $display("FAIL lw_decode: got %b expected %b", outs, E_DEC); end
    cyc;
    checks++; if (outs !== E_ADR) begin errors++; $display("FAIL lw_memadr: got %b expected %b", outs, E_ADR); end
    cyc;
    checks++; if (outs !== E_MEMRD) begin errors++; $display("FAIL lw_memrd: got %b expected %b", outs, E_MEMRD); end
    cyc;
    checks++; if (outs !== E_MEMWB) begin errors++; $display("FAIL lw_memwb: got %b expected %b", outs, E_MEMWB); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL lw_next_fetch: got %b expected %b", outs, E_FETCH); end
    op = 6'b101011;
    cyc; cyc;
    checks++; if (outs !== E_ADR) begin errors++; $display("FAIL sw_memadr: got %b expected %b", outs, E_ADR); end
    cyc;
    checks++; if (outs !== E_MEMWR) begin errors++; $display("FAIL sw_memwr: got %b expected %b", outs, E_MEMWR); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL sw_next_fetch: got %b expected %b", outs, E_FETCH); end
  endtask

  task automatic test_beq;
    op = 6'b000100; zero = 1;
    cyc;
    checks++; if (outs !== E_DEC) begin errors++; $display("FAIL beq_decode_zero_ignored: got %b expected %b", outs, E_DEC); end
    cyc;
    checks++; if (outs !== E_BR_T) begin errors++; $display("FAIL beq_taken: got %b expected %b", outs, E_BR_T); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL beq_next_fetch: got %b expected %b", outs, E_FETCH); end
    zero = 0;
    cyc; cyc;
    checks++; if (outs !== E_BR_N) begin errors++; $display("FAIL beq_not_taken: got %b expected %b", outs, E_BR_N); end
    cyc;
  endtask

  task automatic test_addi_j;
    op = 6'b001000;
    cyc; cyc;
    checks++; if (outs !== E_ADR) begin errors++; $display("FAIL addi_ex: got %b expected %b", outs, E_ADR); end
    cyc;
    checks++; if (outs !== E_ADDIWB) begin errors++; $display("FAIL addi_wb: got %b expected %b", outs, E_ADDIWB); end
    cyc;
    op = 6'b000010;
    cyc; cyc;
    checks++; if (outs !== E_JUMP) begin errors++; $display("FAIL j_jump: got %b expected %b", outs, E_JUMP); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL j_next_fetch: got %b expected %b", outs, E_FETCH); end
  endtask

  task automatic test_illegal;
    op = 6'b111111;
    cyc;
    checks++; if (outs !== E_DECILL) begin errors++; $display("FAIL ill_decode: got %b expected %b", outs, E_DECILL); end
    cyc;
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL ill_next_fetch: got %b expected %b", outs, E_FETCH); end
    op = 6'b000000; funct = 6'b000111;
    cyc;
    checks++; if (outs !== E_DECILL) begin errors++; $display("FAIL badfunct_decode: got %b expected %b", outs, E_DECILL); end
    cyc;
    checks++; if (outs !== {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0}) begin errors++; $display("FAIL badfunct_exec_add: got %b", outs); end
    cyc; cyc;
  endtask

  task automatic test_funct;
    logic [5:0] fn [4] = '{6'b101010, 6'b100010, 6'b100100, 6'b100101};
    logic [2:0] ex [4] = '{3'b111, 3'b110, 3'b000, 3'b001};
    op = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      funct = fn[i];
      cyc;
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL funct_decode_legal %b: got %b expected 0", fn[i], illegal_op); end
      cyc;
      checks++; if (alu_control !== ex[i]) begin errors++; $display("FAIL funct_alu %b: got %b expected %b", fn[i], alu_control, ex[i]); end
      cyc; cyc;
    end
  endtask

  task automatic test_bne;
    op = 6'b000101; zero = 0;
    cyc;
`ifdef MC_BNE_EN
    checks++; if (outs !== E_DEC) begin errors++; $display("FAIL bne_decode: got %b expected %b", outs, E_DEC); end
    cyc;
    checks++; if (outs !== E_BR_T) begin errors++; $display("FAIL bne_taken: got %b expected %b", outs, E_BR_T); end
    zero = 1;
    #1;
    checks++; if (outs !== E_BR_N) begin errors++; $display("FAIL bne_not_taken: got %b expected %b", outs, E_BR_N); end
    cyc;
`else
    checks++; if (outs !== E_DECILL) begin errors++; $display("FAIL bne_illegal: got %b expected %b", outs, E_DECILL); end
    cyc;
`endif
    checks++; if (outs !== E_FETCH) begin errors++; $display("FAIL bne_next_fetch: got %b expected %b", outs, E_FETCH); end
    zero = 0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_lw_sw;
    test_beq;
    test_addi_j;
    test_illegal;
    test_funct;
    test_bne;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
